// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding and latched command record.
// Round-robin arbitration is selected with RAM_ARB_RR_EN (fixed priority otherwise).
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_CAPTURE = 2'd3
  } ram_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [IDX_W-1:0]  idx;
  } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Winner select for the RAM arbiter. RAM_ARB_RR_EN defined: round-robin from a
// registered pointer; undefined: fixed priority, lowest index wins, no pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  output logic               o_vld_c,
  output logic [IDX_W-1:0]   o_idx_c
);

`ifdef RAM_ARB_RR_EN
  localparam int unsigned SW = IDX_W + 1;

  logic [IDX_W-1:0]     r_ptr;
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW-1:0]        w_sum;

  // Rotate requests so the pointer position lands on bit 0
  assign w_req2 = {i_req, i_req};
  assign w_rot  = NUM_REQ'(w_req2 >> r_ptr);

  always_comb begin
    o_vld_c = 1'b0;
    o_idx_c = '0;
    w_sum   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_vld_c = 1'b1;
        w_sum   = SW'(i) + SW'(r_ptr);
      end
    end
    if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
    o_idx_c = IDX_W'(w_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (o_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx_c + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_upd};

  always_comb begin
    o_vld_c = 1'b0;
    o_idx_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_vld_c = 1'b1;
        o_idx_c = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares a tri-state-bus RAM between NUM_REQ requesters: arbitrates, sequences
// cs/rd/wd and the data bus, returns read data. RAM_ARB_RR_EN selects round-robin.
module ram_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W  = ram_ctrl_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]               rdata,
  output logic                            cs,
  output logic                            rd,
  output logic                            wd,
  output logic [ADDR_W-1:0]               addlines,
  inout  wire  [DATA_W-1:0]               datalines,
  output logic                            ram_rst
);
  import ram_ctrl_pkg::*;

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMD_AW = ram_ctrl_pkg::ADDR_W;
  localparam int unsigned CMD_DW = ram_ctrl_pkg::DATA_W;
  localparam int unsigned CMD_IW = ram_ctrl_pkg::IDX_W;

  ram_state_e         r_state, w_state_nxt;
  ram_cmd_t           r_cmd, w_cmd_nxt;
  logic               w_vld, w_upd;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt, r_rvalid, w_rvalid_nxt;
  logic               r_cs, r_rd, r_wd, r_oe;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_unused;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req),
    .i_upd   (w_upd),
    .o_vld_c (w_vld),
    .o_idx_c (w_idx)
  );

  // Next state, command latch and one-cycle pulses
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = r_cmd;
    w_upd        = 1'b0;
    w_gnt_nxt    = '0;
    w_rvalid_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_vld) begin
          w_upd           = 1'b1;
          w_cmd_nxt.we    = we[w_idx];
          w_cmd_nxt.addr  = CMD_AW'(addr[w_idx]);
          w_cmd_nxt.wdata = CMD_DW'(wdata[w_idx]);
          w_cmd_nxt.idx   = CMD_IW'(w_idx);
          w_gnt_nxt       = NUM_REQ'(1) << w_idx;
          w_state_nxt     = we[w_idx] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      S_READ:  w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_state_nxt  = S_IDLE;
        w_rvalid_nxt = NUM_REQ'(1) << r_cmd.idx;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  // Strobes and bus enable are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_cs     <= 1'b0;
      r_rd     <= 1'b0;
      r_wd     <= 1'b0;
      r_oe     <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_cs     <= (w_state_nxt != S_IDLE);
      r_rd     <= (w_state_nxt == S_READ);
      r_wd     <= (w_state_nxt == S_WRITE);
      r_oe     <= (w_state_nxt == S_WRITE);
      if (r_state == S_CAPTURE) r_rdata <= datalines;
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign cs        = r_cs;
  assign rd        = r_rd;
  assign wd        = r_wd;
  assign addlines  = ADDR_W'(r_cmd.addr);
  assign datalines = r_oe ? DATA_W'(r_cmd.wdata) : 'z;
  assign ram_rst   = ~rst_n;
  assign w_unused  = r_cmd.we;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x8 tri-state RAM;
// expectations follow RAM_ARB_RR_EN (round-robin) or its absence (fixed priority).
module tb_ram_arbiter;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [1:0] G1  = RR ? 2'b10 : 2'b01;
  localparam logic [4:0] AW1 = RR ? 5'd2 : 5'd1;
  localparam logic [7:0] DW1 = RR ? 8'h22 : 8'h11;
  localparam int NV = 21;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req, we;
  logic [1:0][4:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt, rvalid;
  logic [7:0]      rdata;
  logic            cs, rd, wd, ram_rst;
  logic [4:0]      addlines;
  wire  [7:0]      datalines;

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .cs(cs), .rd(rd), .wd(wd),
    .addlines(addlines), .datalines(datalines), .ram_rst(ram_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered output, released by a select-without-strobe cycle
  logic [7:0] mem [32];
  logic [7:0] ram_q;
  logic       ram_drv;

  always @(posedge clk or posedge ram_rst) begin
    if (ram_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      ram_q   <= 8'h00;
      ram_drv <= 1'b0;
    end else if (cs) begin
      if (wd) mem[addlines] <= datalines;
      if (rd) begin
        ram_q   <= mem[addlines];
        ram_drv <= 1'b1;
      end else if (!wd) begin
        ram_drv <= 1'b0;
      end
    end
  end
  assign datalines = ram_drv ? ram_q : 8'bz;

  typedef struct {
    logic [1:0] req, we;
    logic [4:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt, rv;
    logic [7:0] rdata;
    logic       cs, rd, wd;
    logic [4:0] addl;
    logic       rel;
    logic [7:0] bus;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [1:0] r, w, input logic [4:0] a0, a1, input logic [7:0] d0, d1,
    input logic [1:0] g, rv, input logic [7:0] rdt, input logic c, rr, ww,
    input logic [4:0] al, input logic rel, input logic [7:0] bus);
    vec_t v;
    v.req = r;  v.we = w;  v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.gnt = g;  v.rv = rv; v.rdata = rdt; v.cs = c; v.rd = rr; v.wd = ww;
    v.addl = al; v.rel = rel; v.bus = bus;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Released bus reads as Z in a 4-state simulator and as 0 in a 2-state one
  task automatic chk_rel(input string name);
    n_vec++;
    if (!($isunknown(datalines) || datalines == 8'h00)) begin
      n_err++;
      $display("FAIL %s: bus driven with %h, expected released", name, datalines);
    end
  endtask

  // Strobe exclusivity and no controller/RAM drive overlap on every active cycle
  always @(negedge clk) begin
    if (rst_n && cs) begin
      chk("mon_rd_wd", 32'(rd & wd), 32'd0);
      chk("mon_contention", 32'(wd & ram_drv), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic       seen_rv, got;
  logic [7:0] got_data;

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;

    //               req    we     a0     a1    d0      d1    | gnt    rv     rdata  cs    rd    wd    addl   rel   bus
    vecs[0]  = mk(2'b01, 2'b01, 5'd20, 5'd0, 8'd69,  8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd20, 1'b0, 8'd69);
    vecs[1]  = mk(2'b00, 2'b00, 5'd20, 5'd0, 8'd69,  8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 5'd20, 1'b1, 8'h00);
    vecs[2]  = mk(2'b01, 2'b00, 5'd20, 5'd0, 8'h00,  8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd20, 1'b1, 8'h00);
    vecs[3]  = mk(2'b00, 2'b00, 5'd20, 5'd0, 8'h00,  8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 5'd20, 1'b0, 8'd69);
    vecs[4]  = mk(2'b00, 2'b00, 5'd20, 5'd0, 8'h00,  8'h00, 2'b00, 2'b01, 8'd69, 1'b0, 1'b0, 1'b0, 5'd20, 1'b1, 8'h00);
    vecs[5]  = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, G1,    2'b00, 8'd69, 1'b1, 1'b0, 1'b1, AW1,   1'b0, DW1);
    vecs[6]  = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, 2'b00, 2'b00, 8'd69, 1'b0, 1'b0, 1'b0, AW1,   1'b1, 8'h00);
    vecs[7]  = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, 2'b01, 2'b00, 8'd69, 1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 8'h11);
    vecs[8]  = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, 2'b00, 2'b00, 8'd69, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 8'h00);
    vecs[9]  = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, G1,    2'b00, 8'd69, 1'b1, 1'b0, 1'b1, AW1,   1'b0, DW1);
    vecs[10] = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, 2'b00, 2'b00, 8'd69, 1'b0, 1'b0, 1'b0, AW1,   1'b1, 8'h00);
    vecs[11] = mk(2'b11, 2'b11, 5'd1,  5'd2, 8'h11,  8'h22, 2'b01, 2'b00, 8'd69, 1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 8'h11);
    vecs[12] = mk(2'b00, 2'b00, 5'd1,  5'd2, 8'h11,  8'h22, 2'b00, 2'b00, 8'd69, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 8'h00);
    vecs[13] = mk(2'b01, 2'b00, 5'd5,  5'd0, 8'h00,  8'h00, 2'b01, 2'b00, 8'd69, 1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 8'h00);
    vecs[14] = mk(2'b01, 2'b01, 5'd5,  5'd0, 8'hA5,  8'h00, 2'b00, 2'b00, 8'd69, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 8'h00);
    vecs[15] = mk(2'b01, 2'b01, 5'd5,  5'd0, 8'hA5,  8'h00, 2'b00, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 8'h00);
    vecs[16] = mk(2'b01, 2'b01, 5'd5,  5'd0, 8'hA5,  8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 8'hA5);
    vecs[17] = mk(2'b01, 2'b00, 5'd5,  5'd0, 8'h00,  8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 8'h00);
    vecs[18] = mk(2'b01, 2'b00, 5'd5,  5'd0, 8'h00,  8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 8'h00);
    vecs[19] = mk(2'b00, 2'b00, 5'd5,  5'd0, 8'h00,  8'h00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 8'hA5);
    vecs[20] = mk(2'b00, 2'b00, 5'd5,  5'd0, 8'h00,  8'h00, 2'b00, 2'b01, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 8'h00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({gnt, rvalid, cs, rd, wd, addlines}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ram_rst", 32'(ram_rst), 32'd1);
    chk_rel("rst_bus");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ram_rst_released", 32'(ram_rst), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req = vecs[i].req; we = vecs[i].we;
      addr[0] = vecs[i].a0; addr[1] = vecs[i].a1;
      wdata[0] = vecs[i].d0; wdata[1] = vecs[i].d1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ctl{gnt,rv,cs,rd,wd,addl}", i),
          32'({gnt, rvalid, cs, rd, wd, addlines}),
          32'({vecs[i].gnt, vecs[i].rv, vecs[i].cs, vecs[i].rd, vecs[i].wd, vecs[i].addl}));
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      if (vecs[i].rel) chk_rel($sformatf("v%0d_bus", i));
      else             chk($sformatf("v%0d_bus", i), 32'(datalines), 32'(vecs[i].bus));
    end

    // Reset asserted in the middle of a READ
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr[0] = 5'd20;
    @(posedge clk);
    #1;
    chk("pre_rst_read", 32'({gnt, cs, rd, wd}), 32'({2'b01, 1'b1, 1'b1, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    req = 2'b00;
    chk("midrst_ctl", 32'({gnt, rvalid, cs, rd, wd, addlines}), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk_rel("midrst_bus");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rvalid != 2'b00) seen_rv = 1'b1;
    end
    chk("midrst_no_rvalid", 32'(seen_rv), 32'd0);

    // First command after reset is served and sees the cleared RAM
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr[0] = 5'd20;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'(2'b01));
    @(negedge clk);
    req = 2'b00;
    got = 1'b0;
    got_data = 8'hFF;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk);
      #1;
      if (rvalid[0]) begin
        got = 1'b1;
        got_data = rdata;
      end
    end
    chk("post_rst_rvalid", 32'(got), 32'd1);
    chk("post_rst_rdata", 32'(got_data), 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
